// File: rtl/game_pkg.sv
// game_pkg: state encoding, point values and timing constants shared by the game-flow block
package game_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_e;
  localparam logic [11:0] PTS_PELLET = 12'h010;
  localparam logic [11:0] PTS_POWER = 12'h050;
  localparam logic [11:0] PTS_GHOST = 12'h200;
  localparam int PELLETS = 244;
  localparam int LIVES_INIT = 3;
  localparam int READY_FRAMES = 120;
  localparam int DEATH_FRAMES = 90;
  localparam int CLEAR_FRAMES = 90;
  localparam int FRIGHT_FRAMES = 360;
endpackage

// File: rtl/game_flow_ctl_if.sv
// game_flow_ctl_if: buttons, gameCtl event strobes and display/control outputs of the game-flow block
interface game_flow_ctl_if;
  logic [3:0] btn;
  logic frame_tick;
  logic pellet_eaten;
  logic power_eaten;
  logic ghost_eaten;
  logic pac_hit;
  logic run_en;
  logic fright;
  logic pos_reset;
  logic maze_reset;
  logic [15:0] score;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] state;
  modport master (
    output btn, frame_tick, pellet_eaten, power_eaten, ghost_eaten, pac_hit,
    input run_en, fright, pos_reset, maze_reset, score, lives, level, state
  );
  modport slave (
    input btn, frame_tick, pellet_eaten, power_eaten, ghost_eaten, pac_hit,
    output run_en, fright, pos_reset, maze_reset, score, lives, level, state
  );
endinterface

// File: rtl/bcd_add_sat.sv
// bcd_add_sat: 4-digit packed BCD plus 3-digit BCD addend, clamped to 9999
module bcd_add_sat (
  input  logic [15:0] a_i,
  input  logic [11:0] b_i,
  output logic [15:0] sum_o
);
  logic [15:0] b;
  logic [15:0] s;
  logic [4:0] t;
  logic c;
  always_comb begin
    b = {4'h0, b_i};
    s = '0;
    t = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, a_i[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'h0, c};
      c = t > 5'd9;
      s[4*i +: 4] = c ? 4'(t - 5'd10) : t[3:0];
    end
    sum_o = c ? 16'h9999 : s;
  end
endmodule

// File: rtl/game_flow_ctl.sv
// game_flow_ctl: Pacman game-flow FSM owning score, lives, level, pellet count and fright timing
module game_flow_ctl
  import game_pkg::*;
(
  input logic clk,
  input logic reset,
  game_flow_ctl_if.slave bus
);
  state_e state_q, state_d;
  logic [3:0] btn_q;
  logic [3:0] level_q, level_d;
  logic [6:0] frm_q, frm_d, frm_lim;
  logic [8:0] frt_q, frt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] score_q, score_d, score_sum;
  logic [11:0] pts;
  logic [1:0] lives_q, lives_d;
  logic fright_q, run_q, posr_q, posr_d, mazr_q, mazr_d;
  logic start, play, eat, timed, frm_done, clear_hit, die_hit, fresh, refill;
  bcd_add_sat u_add (
    .a_i(score_q),
    .b_i(pts),
    .sum_o(score_sum)
  );
  always_comb begin
    start = |(bus.btn & ~btn_q);
    play = state_q == PLAY;
    eat = play & (bus.pellet_eaten | bus.power_eaten);
    timed = (state_q == READY) | (state_q == DYING) | (state_q == CLEAR);
    frm_lim = state_q == READY ? 7'(READY_FRAMES - 1) :
              state_q == DYING ? 7'(DEATH_FRAMES - 1) : 7'(CLEAR_FRAMES - 1);
    frm_done = timed & bus.frame_tick & (frm_q == frm_lim);
    // clearing the maze outranks a fatal ghost contact in the same cycle
    clear_hit = eat & (cnt_q == 8'd1);
    die_hit = play & bus.pac_hit & ~fright_q & ~clear_hit;
    fresh = (state_q == IDLE) & start;
    refill = fresh | ((state_q == CLEAR) & frm_done);
    pts = (bus.pellet_eaten ? PTS_PELLET : 12'h0) + (bus.power_eaten ? PTS_POWER : 12'h0) +
          (bus.ghost_eaten & fright_q ? PTS_GHOST : 12'h0);
    state_d = state_q == IDLE  ? (start ? READY : IDLE) :
              state_q == READY ? (frm_done ? PLAY : READY) :
              state_q == PLAY  ? (clear_hit ? CLEAR : die_hit ? DYING : PLAY) :
              state_q == DYING ? (frm_done ? (lives_q != 2'd0 ? READY : OVER) : DYING) :
              state_q == CLEAR ? (frm_done ? READY : CLEAR) :
              state_q == OVER  ? (start ? IDLE : OVER) : IDLE;
    frm_d = state_d != state_q ? 7'd0 : frm_q + 7'(bus.frame_tick & timed);
    frt_d = state_d != PLAY ? 9'd0 :
            (play & bus.power_eaten) ? 9'(FRIGHT_FRAMES) :
            (bus.frame_tick & (frt_q != 9'd0)) ? frt_q - 9'd1 : frt_q;
    cnt_d = refill ? 8'(PELLETS) : cnt_q - 8'(eat);
    score_d = fresh ? 16'h0 : play ? score_sum : score_q;
    lives_d = fresh ? 2'(LIVES_INIT) : die_hit ? lives_q - 2'd1 : lives_q;
    level_d = fresh ? 4'd1 :
              ((state_q == CLEAR) & frm_done & (level_q != 4'd15)) ? level_q + 4'd1 : level_q;
    posr_d = refill | ((state_q == DYING) & frm_done & (lives_q != 2'd0));
    mazr_d = refill;
  end
  always_ff @(posedge clk) begin
    btn_q <= bus.btn;
    if (reset) begin
      state_q <= IDLE;
      frm_q <= '0;
      frt_q <= '0;
      cnt_q <= 8'(PELLETS);
      score_q <= '0;
      lives_q <= 2'(LIVES_INIT);
      level_q <= 4'd1;
      fright_q <= 1'b0;
      run_q <= 1'b0;
      posr_q <= 1'b0;
      mazr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frm_q <= frm_d;
      frt_q <= frt_d;
      cnt_q <= cnt_d;
      score_q <= score_d;
      lives_q <= lives_d;
      level_q <= level_d;
      fright_q <= frt_d != 9'd0;
      run_q <= state_d == PLAY;
      posr_q <= posr_d;
      mazr_q <= mazr_d;
    end
  end
  assign bus.run_en = run_q;
  assign bus.fright = fright_q;
  assign bus.pos_reset = posr_q;
  assign bus.maze_reset = mazr_q;
  assign bus.score = score_q;
  assign bus.lives = lives_q;
  assign bus.level = level_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_game_flow_ctl.sv
// tb_game_flow_ctl: directed and random stimulus against a decimal game model
module tb_game_flow_ctl;
  import game_pkg::*;
  logic clk = 1'b0;
  logic reset;
  game_flow_ctl_if bus ();
  game_flow_ctl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  state_e ms = IDLE;
  int msc = 0, mlv = LIVES_INIT, mlvl = 1, mcnt = PELLETS, mfrt = 0, mfrm = 0;
  bit mpos = 1'b0, mmaz = 1'b0;
  logic [3:0] mprev = 4'h0;
  logic [3:0] btn_now = 4'h0;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction
  // reference: one clock edge of the game rules, score kept as a plain decimal number
  task automatic model(input logic [3:0] b, input bit tk, pe, pw, gh, hit, rs);
    state_e ns;
    bit st, fr;
    st = |(b & ~mprev);
    mprev = b;
    mpos = 0;
    mmaz = 0;
    if (rs) begin
      ms = IDLE; msc = 0; mlv = LIVES_INIT; mlvl = 1; mcnt = PELLETS; mfrt = 0; mfrm = 0;
      return;
    end
    ns = ms;
    fr = mfrt > 0;
    case (ms)
      IDLE: if (st) begin
        ns = READY; msc = 0; mlv = LIVES_INIT; mlvl = 1; mcnt = PELLETS; mpos = 1; mmaz = 1;
      end
      READY: begin
        if (tk) mfrm++;
        if (mfrm == READY_FRAMES) ns = PLAY;
      end
      PLAY: begin
        if (pe || pw) mcnt--;
        msc = msc + (pe ? 10 : 0) + (pw ? 50 : 0) + ((gh && fr) ? 200 : 0);
        if (msc > 9999) msc = 9999;
        if (pw) mfrt = FRIGHT_FRAMES;
        else if (tk && mfrt > 0) mfrt--;
        if ((pe || pw) && mcnt == 0) ns = CLEAR;
        else if (hit && !fr) begin
          ns = DYING;
          mlv--;
        end
      end
      DYING: begin
        if (tk) mfrm++;
        if (mfrm == DEATH_FRAMES) begin
          ns = mlv > 0 ? READY : OVER;
          mpos = mlv > 0;
        end
      end
      CLEAR: begin
        if (tk) mfrm++;
        if (mfrm == CLEAR_FRAMES) begin
          ns = READY; mlvl = mlvl < 15 ? mlvl + 1 : 15; mcnt = PELLETS; mpos = 1; mmaz = 1;
        end
      end
      OVER: if (st) ns = IDLE;
      default: ns = IDLE;
    endcase
    if (ns != ms) mfrm = 0;
    if (ns != PLAY) mfrt = 0;
    ms = ns;
  endtask
  task automatic cyc(input logic [3:0] b, input bit tk, pe, pw, gh, hit, rs);
    bus.btn = b;
    bus.frame_tick = tk;
    bus.pellet_eaten = pe;
    bus.power_eaten = pw;
    bus.ghost_eaten = gh;
    bus.pac_hit = hit;
    reset = rs;
    @(posedge clk);
    model(b, tk, pe, pw, gh, hit, rs);
    #1;
    chk("state", int'(bus.state), int'(ms));
    chk("score", int'(bus.score), to_bcd(msc));
    chk("lives", int'(bus.lives), mlv);
    chk("level", int'(bus.level), mlvl);
    chk("run_en", int'(bus.run_en), int'(ms == PLAY));
    chk("fright", int'(bus.fright), int'(mfrt > 0));
    chk("pos_reset", int'(bus.pos_reset), int'(mpos));
    chk("maze_reset", int'(bus.maze_reset), int'(mmaz));
  endtask
  task automatic ev(input bit pe, pw, gh, hit);
    cyc(btn_now, 1'b0, pe, pw, gh, hit, 1'b0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(btn_now, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic press(input logic [3:0] b);
    btn_now = b;
    ev(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    repeat (2) cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_lives", int'(bus.lives), 3);
    press(4'h1);
    chk("start_state", int'(bus.state), 1);
    chk("start_pulses", int'({bus.pos_reset, bus.maze_reset}), 3);
    ev(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_one_cycle", int'({bus.pos_reset, bus.maze_reset}), 0);
    ticks(READY_FRAMES - 1);
    chk("ready_hold", int'(bus.state), 1);
    ticks(1);
    chk("play_state", int'(bus.state), 2);
    chk("play_run_en", int'(bus.run_en), 1);
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    chk("power_score", int'(bus.score), 'h0050);
    ev(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sum_260", int'(bus.score), 'h0310);
    repeat (48) ev(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) ev(1'b1, 1'b0, 1'b0, 1'b0);
    chk("score_9990", int'(bus.score), 'h9990);
    ev(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_power", int'(bus.score), 'h9999);
    repeat (3) ev(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", int'(bus.score), 'h9999);
    for (int i = 0; i < 300 && mcnt > 1; i++) ev(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(FRIGHT_FRAMES);
    chk("fright_expired", int'(bus.fright), 0);
    ev(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clear_wins", int'(bus.state), 4);
    chk("clear_lives", int'(bus.lives), 3);
    ticks(CLEAR_FRAMES - 1);
    chk("clear_hold", int'(bus.state), 4);
    ticks(1);
    chk("clear_ready", int'(bus.state), 1);
    chk("level_2", int'(bus.level), 2);
    chk("clear_pulses", int'({bus.pos_reset, bus.maze_reset}), 3);
    repeat (2) begin
      ticks(READY_FRAMES);
      ev(1'b0, 1'b0, 1'b0, 1'b1);
      ticks(DEATH_FRAMES);
    end
    chk("respawn_state", int'(bus.state), 1);
    ticks(READY_FRAMES);
    ev(1'b0, 1'b0, 1'b0, 1'b1);
    chk("last_life_state", int'(bus.state), 3);
    chk("last_life_lives", int'(bus.lives), 0);
    ticks(DEATH_FRAMES);
    chk("over_state", int'(bus.state), 5);
    chk("over_score", int'(bus.score), 'h9999);
    press(4'h3);
    chk("over_idle", int'(bus.state), 0);
    chk("over_no_pulse", int'({bus.pos_reset, bus.maze_reset}), 0);
    press(4'h0);
    press(4'h8);
    ticks(READY_FRAMES);
    repeat (5) ev(1'b1, 1'b0, 1'b0, 1'b0);
    ev(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(30);
    chk("dying_mid", int'(bus.state), 3);
    cyc(btn_now, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_state", int'(bus.state), 0);
    chk("mid_rst_lives", int'(bus.lives), 3);
    chk("mid_rst_score", int'(bus.score), 0);
    chk("mid_rst_run", int'({bus.run_en, bus.fright}), 0);
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 99) < 3) btn_now = 4'($urandom);
      cyc(btn_now, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 1999) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
